// File: rtl/tid_tracker_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tid_tracker_pkg                                                  |
// | Default widths, entry layout and sizing helpers for tid_tracker. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package tid_tracker_pkg;

  localparam int c_TID_W_DEF       = 8;
  localparam int c_DATA_W_DEF      = 20;
  localparam int c_TS_W_DEF        = 16;
  localparam int c_TIMEOUT_CYC_DEF = 16'hFFFF;
  localparam int c_TCQ_DEF         = 100;

  typedef struct packed {
    logic [c_DATA_W_DEF-1:0] data;
    logic [c_TS_W_DEF-1:0]   ts;
  } entry_t;

  function automatic int depth_of(input int tid_w);
    return 1 << tid_w;
  endfunction

  // One extra bit so a completely full table is representable.
  function automatic int cnt_w(input int tid_w);
    return tid_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tid_tracker_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tid_tracker_ram                                                  |
// | Simple dual-port RAM, one write and one registered read port,    |
// | read-first on address collision.                                 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tid_tracker_ram
  import tid_tracker_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WIDTH  = 20
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [0:depth_of(ADDR_W)-1];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/tid_tracker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tid_tracker                                                      |
// | Outstanding-request table keyed by TID with collision, unknown-  |
// | response and flush handling. Define TID_TRACKER_TIMEOUT_EN to    |
// | build the timestamping timeout scanner.                          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tid_tracker
  import tid_tracker_pkg::*;
#(
  parameter int TID_W       = c_TID_W_DEF,
  parameter int DATA_W      = c_DATA_W_DEF,
  parameter int TS_W        = c_TS_W_DEF,
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC_DEF,
  parameter int TCQ         = c_TCQ_DEF
) (
  input  logic              lnk_clk,
  input  logic              lnk_reset_n,
  output logic              trk_rdy,
  output logic [TID_W:0]    trk_pkt_cnt,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [TID_W-1:0]  alloc_tid,
  input  logic [DATA_W-1:0] alloc_data,
  output logic              alloc_ready,
  output logic              alloc_err,
  input  logic              rsp_valid,
  input  logic [TID_W-1:0]  rsp_tid,
  output logic              rsp_out_valid,
  output logic [DATA_W-1:0] rsp_out_data,
  output logic              rsp_out_err,
  output logic              to_valid,
  output logic [TID_W-1:0]  to_tid,
  output logic [DATA_W-1:0] to_data
);

  localparam int c_DEPTH = depth_of(TID_W);
  localparam int c_CNT_W = cnt_w(TID_W);
`ifdef TID_TRACKER_TIMEOUT_EN
  localparam int c_RAM_W = DATA_W + TS_W;
`else
  localparam int c_RAM_W = DATA_W;
`endif

  if (TID_W < 1 || TID_W > 16 || DATA_W < 1 || TS_W < 2 || TS_W > 31 || TCQ < 0 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << TS_W)) begin : g_bad_params
    $error("tid_tracker: illegal parameter set");
  end

  logic               r_rdy;
  logic [c_DEPTH-1:0] r_valid;
  logic [c_DEPTH-1:0] w_valid_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               r_alloc_err;
  logic               r_rsp_vld;
  logic               r_rsp_hit;
  logic               r_rsp_err;
  logic               w_alloc_acc;
  logic               w_alloc_ok;
  logic               w_rsp_fire;
  logic               w_rsp_hit;
  logic               w_expire;
  logic               w_ram_rd_en;
  logic [TID_W-1:0]   w_ram_rd_addr;
  logic [c_RAM_W-1:0] w_ram_wr_data;
  logic [c_RAM_W-1:0] w_ram_rd_data;
  logic [DATA_W-1:0]  w_rd_ctx;

  assign alloc_ready = r_rdy & ~flush;
  assign w_alloc_acc = alloc_valid & alloc_ready;
  assign w_rsp_fire  = rsp_valid & r_rdy;
  assign w_rsp_hit   = w_rsp_fire & r_valid[rsp_tid];
  // A same-cycle retire of the same TID frees the slot for the new allocation.
  assign w_alloc_ok  = w_alloc_acc &
                       (~r_valid[alloc_tid] | (w_rsp_hit & (rsp_tid == alloc_tid)));

`ifdef TID_TRACKER_TIMEOUT_EN
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } ent_t;

  logic [TS_W-1:0]  r_ts;
  logic [TID_W-1:0] r_scan_ptr;
  logic [TID_W-1:0] r_scan_tid;
  logic             r_scan_vld;
  logic             r_scan_kill;
  logic             w_scan_rd;
  ent_t             w_rd_ent;
  logic [TS_W-1:0]  w_age;

  // The scanner borrows the read port only in cycles without a response.
  assign w_scan_rd     = r_rdy & ~rsp_valid;
  assign w_ram_rd_en   = w_rsp_fire | w_scan_rd;
  assign w_ram_rd_addr = rsp_valid ? rsp_tid : r_scan_ptr;
  assign w_ram_wr_data = {alloc_data, r_ts};
  assign w_rd_ent      = w_ram_rd_data;
  assign w_rd_ctx      = w_rd_ent.data;
  assign w_age         = r_ts - w_rd_ent.ts;

  assign w_expire = r_scan_vld & ~r_scan_kill & r_valid[r_scan_tid] &
                    (w_age >= TS_W'(TIMEOUT_CYC)) & ~flush &
                    ~(w_alloc_acc & (alloc_tid == r_scan_tid)) &
                    ~(w_rsp_fire & (rsp_tid == r_scan_tid));

  always_ff @(posedge lnk_clk or negedge lnk_reset_n) begin
    if (!lnk_reset_n) begin
      r_ts        <= '0;
      r_scan_ptr  <= '0;
      r_scan_tid  <= '0;
      r_scan_vld  <= 1'b0;
      r_scan_kill <= 1'b0;
    end else begin
      r_ts       <= r_ts + TS_W'(1);
      r_scan_vld <= w_scan_rd;
      if (w_scan_rd) begin
        r_scan_ptr  <= r_scan_ptr + TID_W'(1);
        r_scan_tid  <= r_scan_ptr;
        r_scan_kill <= flush | (w_alloc_acc & (alloc_tid == r_scan_ptr));
      end
    end
  end

  assign to_valid = w_expire;
  assign to_tid   = w_expire ? r_scan_tid : '0;
  assign to_data  = w_expire ? w_rd_ent.data : '0;
`else
  assign w_expire      = 1'b0;
  assign w_ram_rd_en   = w_rsp_fire;
  assign w_ram_rd_addr = rsp_tid;
  assign w_ram_wr_data = alloc_data;
  assign w_rd_ctx      = w_ram_rd_data;
  assign to_valid      = 1'b0;
  assign to_tid        = '0;
  assign to_data       = '0;
`endif

  always_comb begin
    w_valid_nxt = r_valid;
    if (w_rsp_hit) w_valid_nxt[rsp_tid] = 1'b0;
`ifdef TID_TRACKER_TIMEOUT_EN
    if (w_expire) w_valid_nxt[r_scan_tid] = 1'b0;
`endif
    if (w_alloc_ok) w_valid_nxt[alloc_tid] = 1'b1;
  end

  assign w_cnt_nxt = r_cnt + c_CNT_W'(w_alloc_ok) - c_CNT_W'(w_rsp_hit) - c_CNT_W'(w_expire);

  always_ff @(posedge lnk_clk or negedge lnk_reset_n) begin
    if (!lnk_reset_n) begin
      r_rdy       <= 1'b0;
      r_valid     <= '0;
      r_cnt       <= '0;
      r_alloc_err <= 1'b0;
      r_rsp_vld   <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rdy       <= 1'b1;
      r_valid     <= flush ? '0 : w_valid_nxt;
      r_cnt       <= flush ? '0 : w_cnt_nxt;
      r_alloc_err <= w_alloc_acc & ~w_alloc_ok;
      r_rsp_vld   <= w_rsp_fire;
      r_rsp_hit   <= w_rsp_hit;
      r_rsp_err   <= w_rsp_fire & ~w_rsp_hit;
    end
  end

  tid_tracker_ram #(
    .ADDR_W (TID_W),
    .WIDTH  (c_RAM_W)
  ) u_ram (
    .clk       (lnk_clk),
    .i_wr_en   (w_alloc_ok),
    .i_wr_addr (alloc_tid),
    .i_wr_data (w_ram_wr_data),
    .i_rd_en   (w_ram_rd_en),
    .i_rd_addr (w_ram_rd_addr),
    .o_rd_data (w_ram_rd_data)
  );

  assign trk_rdy       = r_rdy;
  assign trk_pkt_cnt   = r_cnt;
  assign alloc_err     = r_alloc_err;
  assign rsp_out_valid = r_rsp_vld;
  assign rsp_out_err   = r_rsp_err;
  assign rsp_out_data  = r_rsp_hit ? w_rd_ctx : '0;

endmodule
`default_nettype wire
